// File: rtl/display_pkg.sv
// Shared constants and scan-state encoding for the
// 4-digit multiplexed 7-segment driver.
package display_pkg;

  localparam int DIGITS  = 4;
  localparam int DIGIT_W = 4;

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    SCAN0 = 2'd0,
    SCAN1 = 2'd1,
    SCAN2 = 2'd2,
    SCAN3 = 2'd3
  } scan_e;

endpackage

// File: rtl/refresh_prescaler.sv
// Divides clk down to a one-cycle tick every
// REFRESH_DIV cycles to pace the digit scan.
module refresh_prescaler #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/display_scan_mux.sv
// Scans a 4-digit BCD shadow word onto a common-anode
// display, one digit per refresh slot, with zero blanking.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        blank_en,
  output logic [3:0]  bcd,
  output logic [3:0]  an,
  output logic        dp,
  output logic        err
);

  logic        tick;
  scan_e       state_q;
  scan_e       state_d;
  logic [1:0]  idx;
  logic [15:0] shadow;
  logic [3:0]  dp_sh;
  logic [3:0]  nz;
  logic [3:0]  bad;
  logic [3:0]  blanked;
  logic [3:0]  nib;
  logic [3:0]  sel;

  refresh_prescaler #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_presc (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SCAN0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      unique case (state_q)
        SCAN0: state_d = SCAN1;
        SCAN1: state_d = SCAN2;
        SCAN2: state_d = SCAN3;
        SCAN3: state_d = SCAN0;
      endcase
    end
  end

  assign idx = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      dp_sh  <= '0;
    end else if (load) begin
      shadow <= value_in;
      dp_sh  <= dp_in;
    end
  end

  // Invalid nibbles are nonzero, so they stop blanking too
  always_comb begin
    nz  = '0;
    bad = '0;
    for (int k = 0; k < DIGITS; k++) begin
      nz[k]  = |shadow[k*DIGIT_W +: DIGIT_W];
      bad[k] = shadow[k*DIGIT_W +: DIGIT_W] > BCD_MAX;
    end
  end

  always_comb begin
    blanked    = '0;
    blanked[3] = blank_en & ~nz[3];
    blanked[2] = blanked[3] & ~nz[2];
    blanked[1] = blanked[2] & ~nz[1];
  end

  assign nib = shadow[{idx, 2'b00} +: DIGIT_W];
  assign sel = 4'b0001 << idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd <= '0;
      an  <= AN_OFF;
      dp  <= 1'b0;
      err <= 1'b0;
    end else begin
      bcd <= nib;
      an  <= blanked[idx] ? AN_OFF : ~sel;
      dp  <= dp_sh[idx] & ~blanked[idx];
      err <= |bad;
    end
  end

endmodule
